// File: rtl/sram_lat_pkg.sv
//------------------------------------------------------------------------------
// Module   : sram_lat_pkg
// Brief    : Shared types and constants for the sram_lat latency SRAM model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sram_lat_pkg;

  // Transaction state: accept, count down the access latency, present response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Delay-jitter LFSR: x^16 + x^14 + x^13 + x^11 + 1, taps on bits 15/13/12/10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Number of low address bits that select a byte inside one data word.
  function automatic int byte_off_bits(input int data_w);
    return (data_w <= 8) ? 0 : $clog2(data_w / 8);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_lat_lfsr.sv
//------------------------------------------------------------------------------
// Module   : sram_lat_lfsr
// Brief    : 16-bit Fibonacci LFSR used to add random wait cycles.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sram_lat_lfsr
  import sram_lat_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] out
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb = ^(r_lfsr & LFSR_TAPS);

  // Shift left with XOR feedback into bit 0; reseed on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (en) begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

  assign out = r_lfsr;

endmodule

`default_nettype wire

// File: rtl/sram_lat.sv
//------------------------------------------------------------------------------
// Module   : sram_lat
// Brief    : Single-port SRAM model with valid/ready request/response
//            channels, byte-masked writes, range checking and a
//            programmable access latency (one outstanding transaction).
//            Optional macro SRAM_LAT_RAND_DELAY_EN adds 0..2^RAND_BITS-1
//            random extra wait cycles per access from an LFSR.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sram_lat
  import sram_lat_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 1,
  parameter int RAND_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int NBYTES   = DATA_W / 8;
  localparam int OFF_BITS = byte_off_bits(DATA_W);
  localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef SRAM_LAT_RAND_DELAY_EN
  // Must hold LATENCY-1 + (2^RAND_BITS - 1).
  localparam int CNT_W    = $clog2(LATENCY + (1 << RAND_BITS));
`else
  localparam int CNT_W    = 4;
`endif

  if (DATA_W < 8 || (DATA_W % 8) != 0 || LATENCY < 1 || LATENCY > 15 ||
      RAND_BITS < 1) begin : g_bad_params
    $error("sram_lat: illegal parameter combination");
  end

  state_t              r_state;
  logic                r_req_ready;
  logic                r_wen;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [NBYTES-1:0]   r_wmask;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [ADDR_W-1:0]   w_idx_full;
  logic [IDX_W-1:0]    w_idx;
  logic                w_in_range;
  logic                w_accept;
  logic                w_access;
  logic                w_mem_we;
  logic [CNT_W-1:0]    w_cnt_load;
  logic [DATA_W-1:0]   w_rd_word;

  // Word index ignores the byte-offset bits, so unaligned addresses alias.
  assign w_idx_full = r_addr >> OFF_BITS;
  assign w_idx      = w_idx_full[IDX_W-1:0];
  assign w_in_range = (w_idx_full < ADDR_W'(DEPTH));
  assign w_accept   = (r_state == IDLE) && req_valid && r_req_ready;
  assign w_access   = (r_state == WAIT) && (r_cnt == '0);
  assign w_mem_we   = w_access && r_wen && w_in_range;
  assign w_rd_word  = r_mem[w_idx];

`ifdef SRAM_LAT_RAND_DELAY_EN
  logic [15:0] w_lfsr;

  sram_lat_lfsr u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .out (w_lfsr)
  );

  assign w_cnt_load = CNT_W'(LATENCY - 1) + CNT_W'(w_lfsr[RAND_BITS-1:0]);
`else
  assign w_cnt_load = CNT_W'(LATENCY - 1);
`endif

  // Storage: byte-enabled write at the access edge; never cleared by reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (r_wmask[b]) begin
          r_mem[w_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Transaction FSM: accept, latency countdown, hold response until taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b0;
      r_wen        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wmask      <= '0;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_wen       <= req_wen;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_wmask     <= req_wmask;
            r_cnt       <= w_cnt_load;
            r_req_ready <= 1'b0;
            r_state     <= WAIT;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_resp_valid <= 1'b1;
            r_err        <= !w_in_range;
            r_rdata      <= (!r_wen && w_in_range) ? w_rd_word : '0;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_req_ready <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

`default_nettype wire

// File: doc/sram_lat.md
Name: sram_lat

Overview:
- Parametrised, synthesizable single-port SRAM model with valid/ready request and response channels and programmable access latency.
- Successor to the fixed-width, DPI-backed memory stub used by the core's fetch/LSU path.
- Holds its own storage array, supports byte-masked writes, flags out-of-range accesses, and allows one outstanding transaction.
- Sits between the IFU/LSU arbiter and the (future) bus bridge.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width; must be a multiple of 8 and ≥ 8.
- DEPTH, 1024, number of DATA_W words.
- LATENCY, 1, wait cycles from accept to response; legal range 1..15.
- RAND_BITS, 2, width of random extra delay; used only with SRAM_LAT_RAND_DELAY_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_wmask  in  DATA_W/8  byte enables; bit i enables byte i.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  DATA_W  read data; 0 for writes and errors.
- resp_err  out  1  address out of range.

Behaviour:
- States: IDLE, WAIT, RESP (encoded in package enum).
- Reset (rst low, asynchronous) forces:
  - state = IDLE; req_ready = 0 while asserted, 1 from the first clock edge after release.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0, counter = 0.
  - The memory array is not cleared.
  - A reset during WAIT or RESP drops the transaction. A pending write is not applied.
- IDLE:
  - req_ready = 1.
  - On edge E with req_valid && req_ready: latch wen/addr/wdata/wmask, load cnt = LATENCY-1, go to WAIT, drop req_ready.
- WAIT:
  - req_ready = 0.
  - Each edge: if cnt == 0, perform the access and go to RESP; else cnt--.
  - resp_valid therefore rises at edge E+LATENCY.
- Access rules:
  - Word index = addr >> log2(DATA_W/8). Low address bits are ignored; no misalignment error.
  - Index ≥ DEPTH: resp_err = 1, rdata = 0, no array write.
  - Write: update only bytes with wmask bit = 1. wmask = 0 is a legal no-op write with a normal response. resp_rdata = 0.
  - Read: resp_rdata = array word at the access edge.
  - A read following a write to the same word returns the new data.
- RESP:
  - resp_valid = 1. resp_rdata and resp_err are held stable until the handshake completes.
  - On edge with resp_ready: resp_valid = 0, rdata/err cleared, go to IDLE.
  - resp_ready held high gives back-to-back throughput of one transaction per LATENCY+2 cycles.
- Single outstanding transaction. req_valid outside IDLE is ignored and must be held by the master per valid/ready rules.
- resp_ready asserted while resp_valid = 0 has no effect.

Optional Feature:
- Macro: SRAM_LAT_RAND_DELAY_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded to 16'hACE1 on reset, advances every cycle.
  - At accept, cnt = LATENCY-1 + lfsr[RAND_BITS-1:0], giving 0..2^RAND_BITS-1 extra wait cycles to stress the core's handshakes.
  - The counter is widened to hold the maximum.
- Undefined: latency is exactly LATENCY; no LFSR logic is present.

Decomposition:
- Package sram_lat_pkg holds:
  - the state enum typedef (IDLE/WAIT/RESP);
  - LFSR_SEED = 16'hACE1 and the LFSR tap constant;
  - a function computing byte-offset bits from DATA_W.
- One sub-module, sram_lat_lfsr (16-bit LFSR, clk/rst/en/out). It is instantiated only under SRAM_LAT_RAND_DELAY_EN.

Test Plan:
- Reset then idle: rst low mid-cycle -> outputs zero immediately; one edge after release req_ready = 1, resp_valid = 0.
- Write then read: LATENCY = 3; write addr 0x10, data 0xDEADBEEF, mask 0xF -> resp_valid at E+3, err = 0. Read 0x10 -> rdata 0xDEADBEEF at its E+3.
- Byte mask: word 0x10 = 0xDEADBEEF; write 0x11223344 mask 4'b0101 -> subsequent read returns 0xDE22BE44.
- Out of range: DEPTH = 1024; read addr 0x1000 -> resp_err = 1, rdata = 0. Write to 0x1000 leaves word 0 unchanged.
- Backpressure: hold resp_ready = 0 for 5 cycles -> resp_valid, rdata, err stable; req_valid pulses ignored (req_ready = 0). Release -> IDLE next edge.
- Reset mid-WAIT: write to 0x20 accepted, rst low during WAIT -> resp_valid never rises. Later read of 0x20 returns the pre-write value.
